// File: rtl/output_limiter_slew.sv
// Output stage behind the anti-windup IIR filter.
// Stage 1 clamps the signed filter output into a programmable [min,max] window
// and produces the railed flags. Stage 2 optionally limits the per-cycle step
// of the DAC word. The railed flags are delayed so they line up with the DAC
// word built from the same sample. Rail entries are counted for diagnostics.
module output_limiter_slew #(
    parameter int SIGNAL_SIZE = 16,
    parameter int COUNT_SIZE  = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     on_in,
    input  logic [SIGNAL_SIZE+1:0]   signal_in,
    input  logic [SIGNAL_SIZE-1:0]   max_in,
    input  logic [SIGNAL_SIZE-1:0]   min_in,
    input  logic [SIGNAL_SIZE-1:0]   slew_in,
    input  logic                     clear_count_in,
    output logic [SIGNAL_SIZE-1:0]   signal_out,
    output logic [1:0]               railed_out,
    output logic [COUNT_SIZE-1:0]    rail_count_out
);

    localparam int SW = SIGNAL_SIZE;

    // Pipeline and diagnostic state
    logic [SW-1:0]         lim_q,    lim_d;
    logic [1:0]            rail1_q,  rail1_d;
    logic [SW-1:0]         signal_q, signal_d;
    logic [1:0]            railed_q, railed_d;
    logic [COUNT_SIZE-1:0] count_q,  count_d;

    // Stage-1 comparison helpers (limits sign-extended to the filter width)
    logic signed [SW+1:0] max_ext_s;
    logic signed [SW+1:0] min_ext_s;
    logic                 hi_s;
    logic                 lo_s;
    logic                 inverted_s;

    // Stage-2 slew helpers (one extra bit so the difference cannot overflow)
    logic signed [SW:0]   diff_s;
    logic signed [SW:0]   slew_ext_s;
    logic signed [SW:0]   neg_slew_s;
    logic [SW-1:0]        step_up_s;
    logic [SW-1:0]        step_dn_s;
    logic                 rail_entry_s;

    // Stage 1: window compare and clamp of the incoming filter sample
    always_comb begin
        max_ext_s  = {{2{max_in[SW-1]}}, max_in};
        min_ext_s  = {{2{min_in[SW-1]}}, min_in};
        hi_s       = ($signed(signal_in) >= max_ext_s);
        lo_s       = ($signed(signal_in) <= min_ext_s);
        inverted_s = ($signed(min_in) > $signed(max_in));
        lim_d      = signal_in[SW-1:0];
        rail1_d    = 2'b00;
        if (!on_in) begin
            lim_d   = {SW{1'b0}};
            rail1_d = 2'b00;
        end else begin
            rail1_d = {hi_s, lo_s};
            // An inverted window collapses onto max so the output stays defined
            if (inverted_s || hi_s) begin
                lim_d = max_in;
            end else if (lo_s) begin
                lim_d = min_in;
            end else begin
                lim_d = signal_in[SW-1:0];
            end
        end
    end

    // Stage 2: slew-rate limit toward the clamped target; flag alignment delay
    always_comb begin
        diff_s     = $signed({lim_q[SW-1], lim_q}) - $signed({signal_q[SW-1], signal_q});
        slew_ext_s = $signed({1'b0, slew_in});
        neg_slew_s = -slew_ext_s;
        // Modular SW-bit steps are exact: they are only taken when the target
        // lies beyond them, so the true result is always representable.
        step_up_s  = signal_q + slew_in;
        step_dn_s  = signal_q - slew_in;
        signal_d   = lim_q;
        railed_d   = 2'b00;
        if (!on_in) begin
            signal_d = {SW{1'b0}};
            railed_d = 2'b00;
        end else begin
            railed_d = rail1_q;
            if (slew_in == {SW{1'b0}}) begin
                signal_d = lim_q;
            end else if (diff_s > slew_ext_s) begin
                signal_d = step_up_s;
            end else if (diff_s < neg_slew_s) begin
                signal_d = step_dn_s;
            end else begin
                signal_d = lim_q;
            end
        end
    end

    // Rail-entry counter: counts 0->nonzero edges of railed_out, saturating
    always_comb begin
        rail_entry_s = (railed_q == 2'b00) && (railed_d != 2'b00);
        count_d      = count_q;
        if (clear_count_in) begin
            count_d = {COUNT_SIZE{1'b0}};
        end else if (rail_entry_s && (count_q != {COUNT_SIZE{1'b1}})) begin
            count_d = count_q + {{(COUNT_SIZE-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // State registers with synchronous reset dominating every other control
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            lim_q    <= {SW{1'b0}};
            rail1_q  <= 2'b00;
            signal_q <= {SW{1'b0}};
            railed_q <= 2'b00;
            count_q  <= {COUNT_SIZE{1'b0}};
        end else begin
            lim_q    <= lim_d;
            rail1_q  <= rail1_d;
            signal_q <= signal_d;
            railed_q <= railed_d;
            count_q  <= count_d;
        end
    end

    assign signal_out     = signal_q;
    assign railed_out     = railed_q;
    assign rail_count_out = count_q;

endmodule
